// File: rtl/mem_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: requester ids, FSM encoding,
// latched grant record and the address range check.
package mem_arb_pkg;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_TBL  = 2'd1;
    localparam logic [1:0] ID_DATA = 2'd2;
    localparam logic [1:0] ID_INST = 2'd3;

    // Bit positions of the per-port one-hot vectors.
    localparam int PORT_TBL  = 0;
    localparam int PORT_DATA = 1;
    localparam int PORT_INST = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] wstrb;
    } grant_t;

    // Full 22-bit byte address compared against the SRAM byte size.
    function automatic logic addr_in_range(input logic [21:0] addr,
                                           input int unsigned mem_words);
        return {10'd0, addr} < (mem_words << 2);
    endfunction

    function automatic logic [2:0] id_onehot(input logic [1:0] id);
        case (id)
            ID_TBL:  return 3'b001;
            ID_DATA: return 3'b010;
            ID_INST: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: fixed priority tbl > data > inst, with an
// override that hands the port to inst once it has been starved long enough.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       tbl_valid,
    input  logic       data_valid,
    input  logic       inst_valid,
    input  logic       force_inst,
    output logic [2:0] win,
    output logic [1:0] win_id
);

    always_comb begin
        win    = 3'b000;
        win_id = ID_NONE;
        if (force_inst && inst_valid) begin
            win    = 3'b100;
            win_id = ID_INST;
        end else if (tbl_valid) begin
            win    = 3'b001;
            win_id = ID_TBL;
        end else if (data_valid) begin
            win    = 3'b010;
            win_id = ID_DATA;
        end else if (inst_valid) begin
            win    = 3'b100;
            win_id = ID_INST;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single SRAM port shared by MPU table loader, CPU data and CPU fetch.
// IDLE -> ACCESS -> RESP per access; out-of-range requests skip ACCESS.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        tbl_valid,
    input  logic [21:0] tbl_addr,
    output logic        tbl_ready,
    output logic [31:0] tbl_rdata,
    output logic        tbl_err,

    input  logic        data_valid,
    input  logic [21:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_ready,
    output logic [31:0] data_rdata,
    output logic        data_err,

    input  logic        inst_valid,
    input  logic [21:0] inst_addr,
    output logic        inst_ready,
    output logic [31:0] inst_rdata,
    output logic        inst_err,

    output logic [3:0]  mem_wen,
    output logic [21:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  grant_id
);

    state_t             state;
    grant_t             grant;
    logic               resp_err;
    logic [3:0]         starve_cnt;
    logic [2:0]         rdy_q;
    logic [2:0]         err_q;
    logic [2:0][31:0]   rdata_q;

    logic [2:0]         win;
    logic [1:0]         win_id;
    logic               force_inst;
    logic [21:0]        sel_addr;
    logic [3:0]         sel_wstrb;
    logic               sel_in_range;
    logic [2:0]         resp_sel;
    logic [31:0]        resp_data;

    assign force_inst = (starve_cnt == 4'(STARVE_LIMIT));

    mem_arb_pick u_pick (
        .tbl_valid  (tbl_valid),
        .data_valid (data_valid),
        .inst_valid (inst_valid),
        .force_inst (force_inst),
        .win        (win),
        .win_id     (win_id)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wstrb = 4'h0;
        case (win_id)
            ID_TBL:  sel_addr = tbl_addr;
            ID_DATA: begin
                sel_addr  = data_addr;
                sel_wstrb = data_wstrb;
            end
            ID_INST: sel_addr = inst_addr;
            default: ;
        endcase
    end

    assign sel_in_range = addr_in_range(sel_addr, MEM_WORDS);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= '0;
            resp_err   <= 1'b0;
            starve_cnt <= 4'd0;
            rdy_q      <= 3'b000;
            err_q      <= 3'b000;
            rdata_q    <= '0;
            mem_wen    <= 4'h0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            grant_id   <= ID_NONE;
        end else begin
            rdy_q <= 3'b000;
            err_q <= 3'b000;
            case (state)
                IDLE: begin
                    if (|win) begin
                        grant.id    <= win_id;
                        grant.wstrb <= sel_wstrb;
                        grant_id    <= win_id;
                        if (win_id == ID_INST || !inst_valid)
                            starve_cnt <= 4'd0;
                        else if (starve_cnt < 4'(STARVE_LIMIT))
                            starve_cnt <= starve_cnt + 4'd1;
                        if (sel_in_range) begin
                            state     <= ACCESS;
                            resp_err  <= 1'b0;
                            mem_addr  <= {2'b00, sel_addr[21:2]};
                            mem_wen   <= sel_wstrb;
                            mem_wdata <= data_wdata;
                        end else begin
                            // Rejected: memory outputs are left untouched.
                            state    <= RESP;
                            resp_err <= 1'b1;
                            rdy_q    <= win;
                            err_q    <= win;
                        end
                    end else if (!inst_valid) begin
                        starve_cnt <= 4'd0;
                    end
                end
                ACCESS: begin
                    state   <= RESP;
                    mem_wen <= 4'h0;
                    rdy_q   <= id_onehot(grant.id);
                end
                RESP: begin
                    state    <= IDLE;
                    grant_id <= ID_NONE;
                    for (int p = 0; p < 3; p++)
                        if (resp_sel[p]) rdata_q[p] <= resp_data;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM data arrives during RESP, so the owner sees it live and the
    // register only holds it once the pulse is over.
    assign resp_sel  = (state == RESP) ? id_onehot(grant.id) : 3'b000;
    assign resp_data = (resp_err || (|grant.wstrb)) ? 32'h0 : mem_rdata;

    assign tbl_rdata  = resp_sel[PORT_TBL]  ? resp_data : rdata_q[PORT_TBL];
    assign data_rdata = resp_sel[PORT_DATA] ? resp_data : rdata_q[PORT_DATA];
    assign inst_rdata = resp_sel[PORT_INST] ? resp_data : rdata_q[PORT_INST];

    assign tbl_ready  = rdy_q[PORT_TBL];
    assign data_ready = rdy_q[PORT_DATA];
    assign inst_ready = rdy_q[PORT_INST];
    assign tbl_err    = err_q[PORT_TBL];
    assign data_err   = err_q[PORT_DATA];
    assign inst_err   = err_q[PORT_INST];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered SRAM model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        tbl_valid = 1'b0, data_valid = 1'b0, inst_valid = 1'b0;
    logic [21:0] tbl_addr = '0, data_addr = '0, inst_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_wstrb = 4'h0;
    logic        tbl_ready, data_ready, inst_ready;
    logic [31:0] tbl_rdata, data_rdata, inst_rdata;
    logic        tbl_err, data_err, inst_err;
    logic [3:0]  mem_wen;
    logic [21:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  grant_id;

    int checks = 0;
    int failures = 0;

    logic [31:0] sram [0:1023];

    mem_port_arbiter #(.MEM_WORDS(1024), .STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .tbl_valid(tbl_valid), .tbl_addr(tbl_addr), .tbl_ready(tbl_ready),
        .tbl_rdata(tbl_rdata), .tbl_err(tbl_err),
        .data_valid(data_valid), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_wstrb(data_wstrb), .data_ready(data_ready), .data_rdata(data_rdata),
        .data_err(data_err),
        .inst_valid(inst_valid), .inst_addr(inst_addr), .inst_ready(inst_ready),
        .inst_rdata(inst_rdata), .inst_err(inst_err),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wen[b]) sram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= sram[mem_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] sim_exp [1:9];

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 32'hA500_0000 | i;
        sim_exp = '{5'b01000, 5'b01100, 5'b00000, 5'b10000, 5'b10010,
                    5'b00000, 5'b11000, 5'b11001, 5'b00000};

        // reset state
        #3 resetn = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_wen",   32'(mem_wen), 32'h0);
        chk("rst_addr",  32'(mem_addr), 32'h0);
        chk("rst_gid",   32'(grant_id), 32'h0);
        chk("rst_rdy",   32'({tbl_ready, data_ready, inst_ready}), 32'h0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        resetn = 1'b1;
        tick();
        chk("idle_gid", 32'(grant_id), 32'h0);

        // reset aborts an in-flight write
        data_valid = 1'b1; data_addr = 22'h10; data_wdata = 32'h1111_2222; data_wstrb = 4'hF;
        tick();
        chk("abort_pre_wen", 32'(mem_wen), 32'hF);
        #2 resetn = 1'b0;
        #1;
        chk("abort_wen",   32'(mem_wen), 32'h0);
        chk("abort_state", 32'(dut.state), 32'(IDLE));
        chk("abort_gid",   32'(grant_id), 32'h0);
        data_valid = 1'b0;
        #1 resetn = 1'b1;
        tick();
        chk("abort_nordy", 32'(data_ready), 32'h0);

        // data write then read
        data_valid = 1'b1; data_addr = 22'h40; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF;
        tick();
        chk("wr_gid",  32'(grant_id), 32'h2);
        chk("wr_addr", 32'(mem_addr), 32'h10);
        chk("wr_wen",  32'(mem_wen), 32'hF);
        chk("wr_rdy_early", 32'(data_ready), 32'h0);
        tick();
        chk("wr_rdy",    32'(data_ready), 32'h1);
        chk("wr_wen_off", 32'(mem_wen), 32'h0);
        chk("wr_rdata0", data_rdata, 32'h0);
        data_valid = 1'b0;
        tick();
        chk("wr_idle", 32'({grant_id, data_ready}), 32'h0);
        data_valid = 1'b1; data_wstrb = 4'h0;
        tick();
        chk("rd_wen", 32'(mem_wen), 32'h0);
        tick();
        chk("rd_rdy",   32'(data_ready), 32'h1);
        chk("rd_rdata", data_rdata, 32'hDEAD_BEEF);
        data_valid = 1'b0;
        tick();
        chk("rd_hold", data_rdata, 32'hDEAD_BEEF);

        // aborted write never reached memory
        data_valid = 1'b1; data_addr = 22'h10;
        tick(); tick();
        chk("abort_mem", data_rdata, 32'hA500_0004);
        data_valid = 1'b0;
        tick();

        // simultaneous requests
        tbl_valid = 1'b1; tbl_addr = 22'h100;
        data_valid = 1'b1; data_addr = 22'h40; data_wstrb = 4'h0;
        inst_valid = 1'b1; inst_addr = 22'h40;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("sim_c%0d", c), 32'({grant_id, tbl_ready, data_ready, inst_ready}),
                32'(sim_exp[c]));
            if (c == 2) chk("sim_tbl_rdata", tbl_rdata, 32'hA500_0040);
            if (c == 8) chk("sim_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
            if (tbl_ready)  tbl_valid  = 1'b0;
            if (data_ready) data_valid = 1'b0;
            if (inst_ready) inst_valid = 1'b0;
        end

        // starvation: tbl held, inst waits, fifth grant forced to inst
        tbl_valid = 1'b1; tbl_addr = 22'h8;
        inst_valid = 1'b1; inst_addr = 22'h4;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c % 3 == 1)
                chk($sformatf("starve_gid_c%0d", c), 32'(grant_id), (c == 13) ? 32'h3 : 32'h1);
            if (c == 10) chk("starve_cnt_sat", 32'(dut.starve_cnt), 32'h4);
            if (c == 13) chk("starve_cnt_clr", 32'(dut.starve_cnt), 32'h0);
            if (c == 14) chk("starve_inst_rdy", 32'(inst_ready), 32'h1);
        end
        tbl_valid = 1'b0; inst_valid = 1'b0;
        tick();

        // range boundary
        inst_valid = 1'b1; inst_addr = 22'hFFC;
        tick();
        chk("rng_hi_gid",  32'(grant_id), 32'h3);
        chk("rng_hi_addr", 32'(mem_addr), 32'h3FF);
        tick();
        chk("rng_hi_rdy", 32'({inst_ready, inst_err}), 32'h2);
        chk("rng_hi_rdata", inst_rdata, 32'hA500_03FF);
        inst_valid = 1'b0;
        tick();
        inst_valid = 1'b1; inst_addr = 22'h1000;
        tick();
        chk("rng_err_rdy",   32'({inst_ready, inst_err}), 32'h3);
        chk("rng_err_wen",   32'(mem_wen), 32'h0);
        chk("rng_err_addr",  32'(mem_addr), 32'h3FF);
        chk("rng_err_rdata", inst_rdata, 32'h0);
        chk("rng_err_gid",   32'(grant_id), 32'h3);
        inst_valid = 1'b0;
        tick();
        chk("rng_err_idle", 32'({grant_id, inst_ready, inst_err}), 32'h0);
        chk("rng_err_hold", inst_rdata, 32'h0);

        // valid dropped during ACCESS of a write
        data_valid = 1'b1; data_addr = 22'h80; data_wdata = 32'h1234_5678; data_wstrb = 4'hF;
        tick();
        data_valid = 1'b0;
        data_addr = 22'h3FC; data_wdata = 32'h0;
        chk("drop_wen",  32'(mem_wen), 32'hF);
        chk("drop_addr", 32'(mem_addr), 32'h20);
        tick();
        chk("drop_rdy", 32'(data_ready), 32'h1);
        tick();
        chk("drop_mem", sram[32], 32'h1234_5678);
        chk("drop_idle", 32'(dut.state), 32'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
